trace_command_issuer: RTL and testbench

//  Producer end of the cache simulation command interface. Accepts parsed trace lines
//  (command, address, end-of-trace flag) from the trace loader over a valid/ready handshake.

---
 rtl/trace_command_issuer_if.sv | 28 ++
 rtl/trace_command_issuer.sv | 158 +++++++++++++++
 tb/tb_trace_command_issuer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_command_issuer_if.sv
// Loader-side trace line handshake plus the command/address/mode bus decoded by the caches.
interface trace_command_issuer_if #(
    parameter int unsigned ADDR_BITS = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_command;
    logic [ADDR_BITS-1:0] in_address;
    logic                 in_last;
    logic                 mode_in;
    logic [3:0]           command;
    logic [ADDR_BITS-1:0] address;
    logic                 mode;
    logic                 done;
    logic [31:0]          issue_count;
    logic [31:0]          bad_count;

    // master: the issuer itself; slave: loader and caches around it
    modport master (
        input  in_valid, in_command, in_address, in_last, mode_in,
        output in_ready, command, address, mode, done, issue_count, bad_count
    );

    modport slave (
        output in_valid, in_command, in_address, in_last, mode_in,
        input  in_ready, command, address, mode, done, issue_count, bad_count
    );
endinterface

// File: rtl/trace_command_issuer.sv
// Buffers parsed trace lines in a FIFO and issues at most one cache command per clock,
// then drains with NOPs and raises a sticky done flag after the final line.
module trace_command_issuer #(
    parameter int unsigned ADDR_BITS    = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    trace_command_issuer_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [3:0]  NOP   = 4'hF;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [3:0]           cmd;
        logic [ADDR_BITS-1:0] addr;
        logic                 last;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               head;
    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DRN_W-1:0]     drain_q, drain_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 mode_q, mode_d;
    logic [31:0]          issue_q, issue_d;
    logic [31:0]          bad_q, bad_d;
    logic                 full, empty, ready, push, pop, flush;

    function automatic logic legal_op(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: legal_op = 1'b1;
            default:                                  legal_op = 1'b0;
        endcase
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign ready = !full && (state_q != DONE);
    assign push  = bus.in_valid && ready;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        cmd_d    = NOP;
        addr_d   = addr_q;
        mode_d   = mode_q;
        issue_d  = issue_q;
        bad_d    = bad_q;
        pop      = 1'b0;
        flush    = 1'b0;

        case (state_q)
            IDLE: begin
                if (push) begin
                    mode_d  = bus.mode_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (legal_op(head.cmd)) begin
                        cmd_d   = head.cmd;
                        addr_d  = head.addr;
                        issue_d = (issue_q == '1) ? issue_q : issue_q + 32'd1;
                    end else begin
                        bad_d   = (bad_q == '1) ? bad_q : bad_q + 32'd1;
                    end
                    if (head.last) begin
                        state_d = DRAIN;
                        drain_d = DRN_W'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                // counter reaches zero after DRAIN_CYCLES NOPs; the next edge enters DONE
                if (drain_q == '0) begin
                    state_d = DONE;
                    flush   = 1'b1;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            DONE: begin
                flush = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= NOP;
            addr_q   <= '0;
            mode_q   <= 1'b0;
            issue_q  <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            issue_q  <= issue_d;
            bad_q    <= bad_d;
        end
    end

    // storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_command, bus.in_address, bus.in_last};
        end
    end

    assign bus.in_ready    = ready;
    assign bus.command     = cmd_q;
    assign bus.address     = addr_q;
    assign bus.mode        = mode_q;
    assign bus.done        = (state_q == DONE);
    assign bus.issue_count = issue_q;
    assign bus.bad_count   = bad_q;
endmodule

// File: tb/tb_trace_command_issuer.sv
// Self-checking bench: table-driven trace groups scored against the issued command stream,
// plus hand sequences for FIFO-full flushing and mid-run reset.
module tb_trace_command_issuer;
    localparam int unsigned AW    = 32;
    localparam int          DRAIN = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trace_command_issuer_if #(.ADDR_BITS(AW)) tif ();
    trace_command_issuer_if #(.ADDR_BITS(AW)) tif2 ();

    trace_command_issuer #(.ADDR_BITS(AW), .DEPTH(8), .DRAIN_CYCLES(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    // small FIFO with a long drain so lines offered after the last one can fill it
    trace_command_issuer #(.ADDR_BITS(AW), .DEPTH(4), .DRAIN_CYCLES(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (tif2)
    );

    typedef struct {
        int           grp;
        logic [3:0]   cmd;
        logic [AW-1:0] addr;
        logic         last;
        logic         mode_in;
        logic [3:0]   exp_cmd;
        logic [AW-1:0] exp_addr;
        logic         exp_mode;
    } vec_t;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [AW-1:0] addr;
        logic          done;
        logic          rdy;
    } obs_t;

    localparam int NGRP = 5;

    vec_t vec[$];
    exp_t exp_q[$];
    obs_t log_q[$];
    bit   logging = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        obs_t o;
        if (logging) begin
            o.cmd  = tif.command;
            o.addr = tif.address;
            o.done = tif.done;
            o.rdy  = tif.in_ready;
            log_q.push_back(o);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int g, input logic [3:0] c, input logic [AW-1:0] a, input logic l,
                       input logic m, input logic [3:0] ec, input logic [AW-1:0] ea, input logic em);
        vec_t v;
        v.grp = g; v.cmd = c; v.addr = a; v.last = l; v.mode_in = m;
        v.exp_cmd = ec; v.exp_addr = ea; v.exp_mode = em;
        vec.push_back(v);
    endtask

    task automatic do_reset();
        tif.in_valid  = 1'b0;
        tif2.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic [AW-1:0] a, input logic l, input logic m);
        int w;
        w = 0;
        tif.in_valid   = 1'b1;
        tif.in_command = c;
        tif.in_address = a;
        tif.in_last    = l;
        tif.mode_in    = m;
        forever begin
            @(negedge clk);
            if (tif.in_ready) break;
            w++;
            if (w > 50) begin
                chk("send_ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1 tif.in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k, n, w, n_issue, n_bad, acc, nonf;
        logic exp_mode;

        tif.in_valid = 1'b0; tif.in_command = '0; tif.in_address = '0; tif.in_last = 1'b0; tif.mode_in = 1'b0;
        tif2.in_valid = 1'b0; tif2.in_command = '0; tif2.in_address = '0; tif2.in_last = 1'b0; tif2.mode_in = 1'b0;

        // basic three-line trace; mode latched from the first line only
        add(0, 4'd2, 32'h1000, 1'b0, 1'b1, 4'd2, 32'h1000, 1'b1);
        add(0, 4'd0, 32'h2000, 1'b0, 1'b0, 4'd0, 32'h2000, 1'b1);
        add(0, 4'd1, 32'h2000, 1'b1, 1'b0, 4'd1, 32'h2000, 1'b1);
        // illegal opcode between legal ones: NOP issued, address held
        add(1, 4'd0, 32'h40,   1'b0, 1'b0, 4'd0, 32'h40,   1'b0);
        add(1, 4'd6, 32'h50,   1'b0, 1'b0, 4'hF, 32'h40,   1'b0);
        add(1, 4'd1, 32'h60,   1'b1, 1'b0, 4'd1, 32'h60,   1'b0);
        // PRINT as the final line
        add(2, 4'd4, 32'h100,  1'b0, 1'b0, 4'd4, 32'h100,  1'b0);
        add(2, 4'd9, 32'hABC,  1'b1, 1'b0, 4'd9, 32'hABC,  1'b0);
        // nine-line burst with valid held, every legal opcode
        add(3, 4'd0, 32'h200,  1'b0, 1'b0, 4'd0, 32'h200,  1'b0);
        add(3, 4'd1, 32'h204,  1'b0, 1'b1, 4'd1, 32'h204,  1'b0);
        add(3, 4'd2, 32'h208,  1'b0, 1'b1, 4'd2, 32'h208,  1'b0);
        add(3, 4'd3, 32'h20C,  1'b0, 1'b1, 4'd3, 32'h20C,  1'b0);
        add(3, 4'd4, 32'h210,  1'b0, 1'b1, 4'd4, 32'h210,  1'b0);
        add(3, 4'd8, 32'h214,  1'b0, 1'b1, 4'd8, 32'h214,  1'b0);
        add(3, 4'd9, 32'h218,  1'b0, 1'b1, 4'd9, 32'h218,  1'b0);
        add(3, 4'd0, 32'h21C,  1'b0, 1'b1, 4'd0, 32'h21C,  1'b0);
        add(3, 4'd1, 32'h220,  1'b1, 1'b1, 4'd1, 32'h220,  1'b0);
        // illegal opcode carrying the last flag still ends the trace
        add(4, 4'd3, 32'h7,    1'b0, 1'b1, 4'd3, 32'h7,    1'b1);
        add(4, 4'd15, 32'h8,   1'b1, 1'b0, 4'hF, 32'h7,    1'b1);

        do_reset();
        chk("rst_command", tif.command, 4'hF);
        chk("rst_address", tif.address, '0);
        chk("rst_mode", tif.mode, 1'b0);
        chk("rst_done", tif.done, 1'b0);
        chk("rst_issue", tif.issue_count, 32'd0);
        chk("rst_bad", tif.bad_count, 32'd0);
        chk("rst_ready", tif.in_ready, 1'b1);

        for (int g = 0; g < NGRP; g++) begin
            n_issue = 0; n_bad = 0; w = 0; exp_mode = 1'b0;
            do_reset();
            log_q.delete();
            exp_q.delete();
            logging = 1'b1;
            for (int i = 0; i < vec.size(); i++) begin
                if (vec[i].grp == g) begin
                    e.cmd  = vec[i].exp_cmd;
                    e.addr = vec[i].exp_addr;
                    exp_q.push_back(e);
                    if (vec[i].exp_cmd == 4'hF) n_bad++; else n_issue++;
                    exp_mode = vec[i].exp_mode;
                    send(vec[i].cmd, vec[i].addr, vec[i].last, vec[i].mode_in);
                end
            end
            while (!tif.done && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("g%0d_done", g), tif.done, 1'b1);
            repeat (2) @(negedge clk);
            logging = 1'b0;

            k = 0;
            while (k < log_q.size() && log_q[k].cmd == 4'hF) k++;
            n = exp_q.size();
            chk($sformatf("g%0d_stream_len", g), (log_q.size() >= k + n + DRAIN + 1), 1'b1);
            if (log_q.size() >= k + n + DRAIN + 1) begin
                for (int j = 0; j < n; j++) begin
                    e = exp_q.pop_front();
                    chk($sformatf("g%0d_cmd%0d", g, j), log_q[k+j].cmd, e.cmd);
                    chk($sformatf("g%0d_addr%0d", g, j), log_q[k+j].addr, e.addr);
                end
                for (int d = 1; d <= DRAIN; d++)
                    chk($sformatf("g%0d_drain_nop%0d", g, d), {log_q[k+n-1+d].cmd, log_q[k+n-1+d].done}, {4'hF, 1'b0});
                chk($sformatf("g%0d_done_timing", g), log_q[k+n+DRAIN].done, 1'b1);
                chk($sformatf("g%0d_ready_after_done", g), log_q[k+n+DRAIN].rdy, 1'b0);
            end
            chk($sformatf("g%0d_issue_count", g), tif.issue_count, n_issue);
            chk($sformatf("g%0d_bad_count", g), tif.bad_count, n_bad);
            chk($sformatf("g%0d_mode", g), tif.mode, exp_mode);
            chk($sformatf("g%0d_cmd_after_done", g), tif.command, 4'hF);
        end

        // reset while the issuer is mid-trace: a buffered line must never appear
        do_reset();
        send(4'd1, 32'h11, 1'b0, 1'b1);
        send(4'd2, 32'h22, 1'b0, 1'b1);
        chk("mid_pre_cmd", tif.command, 4'd1);
        chk("mid_pre_mode", tif.mode, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cmd", tif.command, 4'hF);
        chk("mid_rst_addr", tif.address, '0);
        chk("mid_rst_mode", tif.mode, 1'b0);
        chk("mid_rst_issue", tif.issue_count, 32'd0);
        chk("mid_rst_ready", tif.in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        nonf = 0;
        repeat (8) begin
            @(negedge clk);
            if (tif.command != 4'hF || tif.done) nonf++;
        end
        chk("mid_no_issue_after_release", nonf, 0);
        chk("mid_issue_after_release", tif.issue_count, 32'd0);

        // lines offered after the last one fill the FIFO during drain and are flushed
        do_reset();
        tif2.in_command = 4'd3; tif2.in_address = 32'h30; tif2.in_last = 1'b1; tif2.mode_in = 1'b0;
        tif2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        tif2.in_command = 4'd1; tif2.in_last = 1'b0; tif2.in_address = 32'h31;
        acc = 0; nonf = 0; w = 0;
        while (!tif2.done && w < 40) begin
            @(negedge clk);
            if (tif2.in_valid && tif2.in_ready) acc++;
            if (tif2.command != 4'hF) nonf++;
            w++;
        end
        chk("full_done", tif2.done, 1'b1);
        chk("full_accepted_after_last", acc, 4);
        chk("full_issued", nonf, 1);
        chk("full_issue_count", tif2.issue_count, 32'd1);
        chk("full_ready_done", tif2.in_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("full_flushed_cmd", tif2.command, 4'hF);
        chk("full_flushed_issue", tif2.issue_count, 32'd1);
        tif2.in_valid = 1'b0;

        // reset with four lines buffered behind the final one
        do_reset();
        tif2.in_command = 4'd2; tif2.in_address = 32'h40; tif2.in_last = 1'b1; tif2.mode_in = 1'b1;
        tif2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        tif2.in_command = 4'd4; tif2.in_last = 1'b0; tif2.in_address = 32'h44;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tif2.in_ready && w < 20);
        chk("buf_full_reached", tif2.in_ready, 1'b0);
        chk("buf_pre_mode", tif2.mode, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("buf_rst_cmd", tif2.command, 4'hF);
        chk("buf_rst_addr", tif2.address, '0);
        chk("buf_rst_mode", tif2.mode, 1'b0);
        chk("buf_rst_done", tif2.done, 1'b0);
        chk("buf_rst_issue", tif2.issue_count, 32'd0);
        chk("buf_rst_ready", tif2.in_ready, 1'b1);
        tif2.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        nonf = 0;
        repeat (12) begin
            @(negedge clk);
            if (tif2.command != 4'hF || tif2.done) nonf++;
        end
        chk("buf_no_issue_after_release", nonf, 0);
        chk("buf_issue_after_release", tif2.issue_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
